hazard_pipe_regs: RTL and testbench
===================================

Name: hazard_pipe_regs

Overview:
- Consumer end of the hazard-control interface: holds PC, Fetch/Decode and Decode/Execute pipeline registers, and applies StallF/StallD/FlushD/FlushE from the hazard unit.
- Carries decode control/data into Execute, inserts bubbles on flush, and tracks per-stage valid bits.
- Keeps saturating stall/flush event counters and a sticky protocol-error flag for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall/flush counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PC
- StallD  in  1  hold F/D register
- FlushD  in  1  branch taken or jump in Decode: clear F/D
- FlushE  in  1  clear D/E register to a bubble
- PCNextF  in  32  next PC from the PC mux
- InstrF  in  32  fetched instruction
- PCPlus4F  in  32  PC+4 from Fetch
- CtrlD  in  $bits(ctrl_t)  decode control bundle (RegWrite, MemToReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst)
- RD1D, RD2D, SignImmD  in  32 each  register operands and immediate
- RsD, RtD, RdD  in  5 each  register specifiers
- PCF  out  32  current PC
- InstrD, PCPlus4D  out  32 each  F/D contents
- ValidD, ValidE  out  1 each  stage holds a real instruction
- CtrlE  out  $bits(ctrl_t)  Execute control
- RD1E, RD2E, SignImmE  out  32 each
- RsE, RtE, RdE  out  5 each
- StallCnt, FlushCnt  out  CNT_W each  event counters
- ProtoErr  out  1  sticky illegal-combination flag

Behaviour:
- All registers update on rising clk. Reset wins over every other input.
- Reset values:
  - PCF = RESET_PC; all other outputs 0.
  - ValidD = ValidE = 0, CtrlE = '0, ProtoErr = 0.
- PC register:
  - StallF=1: hold.
  - Otherwise PCF <= PCNextF.
- F/D register, priority StallD > FlushD:
  - StallD=1: hold InstrD, PCPlus4D, ValidD.
  - Else FlushD=1: InstrD <= 0, PCPlus4D <= 0, ValidD <= 0.
  - Else load InstrF, PCPlus4F; ValidD <= 1.
- D/E register (has no enable):
  - FlushE=1: CtrlE <= '0, all data/specifier fields <= 0, ValidE <= 0.
  - Else load all D fields; ValidE <= ValidD.
- Latency: one cycle per stage; an instruction fetched at cycle n appears in E at n+2 if nothing stalls.
- A bubble (ValidE=0, CtrlE=0) must never write a register or memory. Zeroed CtrlE guarantees this.
- StallCnt increments each cycle StallD=1.
- FlushCnt increments each cycle FlushE=1 or (FlushD=1 and StallD=0).
- Both counters saturate at all-ones and do not wrap.
- ProtoErr sets when StallD != StallF or (StallD=1 and FlushE=0); cleared only by reset.
  - The register actions above still apply exactly as specified when ProtoErr sets.
- Simultaneous StallD and FlushE, the normal lw/branch stall case: D holds and E gets a bubble. Counters: StallCnt+1, FlushCnt+1.
- Reset mid-stall: all state returns to reset values next cycle; stall inputs are ignored during reset.

Decomposition:
- Package mips_pipe_pkg holds:
  - ctrl_t packed struct: regwrite, memtoreg, memwrite, alucontrol[2:0], alusrc, regdst.
  - CTRL_BUBBLE = '0.
  - RESET_PC default.
- One natural sub-module, pipe_flop_enc: a parameterised-width flop with synchronous reset, enable and clear, clear lower priority than enable-hold.
  - Instantiated for PC, F/D and D/E; D/E ties enable high.

Test Plan:
- Reset then free-run with PCNextF = PCF+4 → PCF = 0,4,8; InstrF=32'h8C08_0004 at cycle 1 appears on InstrD at cycle 2; its CtrlE/RsE appear at cycle 3 with ValidE=1.
- lw-use: StallF=StallD=FlushE=1 for one cycle → PCF and InstrD unchanged, CtrlE=0, ValidE=0, StallCnt=1, FlushCnt=1, ProtoErr=0.
- Taken branch: FlushD=1, StallD=0 → next cycle InstrD=0, ValidD=0, PCF=PCNextF target (e.g. 32'h40); FlushCnt increments.
- FlushD=1 and StallD=1 together → F/D holds old InstrD, ValidD stays 1.
- Illegal StallD=1, StallF=0 → ProtoErr=1 and stays 1 after inputs return legal; cleared by reset.
- CNT_W=4 with StallD held 20 cycles → StallCnt saturates at 15; reset asserted mid-stall clears StallCnt to 0 and PCF to RESET_PC.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline register slice.
package mips_pipe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_IDXW = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic       regdst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Fetch/Decode payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } fd_t;

  // Decode/Execute payload
  typedef struct packed {
    ctrl_t               ctrl;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     signimm;
    logic [REG_IDXW-1:0] rs;
    logic [REG_IDXW-1:0] rt;
    logic [REG_IDXW-1:0] rd;
    logic                valid;
  } de_t;

  localparam int unsigned FD_W = $bits(fd_t);
  localparam int unsigned DE_W = $bits(de_t);

endpackage

// File: rtl/pipe_flop_enc.sv
// Width-parameterised pipeline flop: sync reset, enable, and clear.
// A deasserted enable holds the value even if clear is requested.
module pipe_flop_enc #(
  parameter int unsigned  W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? '0 : d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, F/D and D/E pipeline registers driven by hazard-unit stall/flush,
// plus saturating stall/flush counters and a sticky protocol-error flag.
module hazard_pipe_regs
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic [31:0]      PCNextF,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  ctrl_t            CtrlD,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  input  logic [31:0]      SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             ValidE,
  output ctrl_t            CtrlE,
  output logic [31:0]      RD1E,
  output logic [31:0]      RD2E,
  output logic [31:0]      SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic             ProtoErr
);

  fd_t fd_d, fd_q;
  de_t de_d, de_q;

  pipe_flop_enc #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(~StallF), .clr(1'b0), .d(PCNextF), .q(PCF)
  );

  assign fd_d = '{instr: InstrF, pcplus4: PCPlus4F, valid: 1'b1};

  pipe_flop_enc #(.W(FD_W), .RST_VAL(FD_W'(0))) u_fd (
    .clk(clk), .reset(reset), .en(~StallD), .clr(FlushD), .d(fd_d), .q(fd_q)
  );

  // ValidE follows ValidD, so a flushed or reset D slot propagates as a bubble
  assign de_d = '{ctrl: CtrlD, rd1: RD1D, rd2: RD2D, signimm: SignImmD,
                  rs: RsD, rt: RtD, rd: RdD, valid: fd_q.valid};

  pipe_flop_enc #(.W(DE_W), .RST_VAL(DE_W'(0))) u_de (
    .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE), .d(de_d), .q(de_q)
  );

  assign InstrD   = fd_q.instr;
  assign PCPlus4D = fd_q.pcplus4;
  assign ValidD   = fd_q.valid;
  assign CtrlE    = de_q.ctrl;
  assign RD1E     = de_q.rd1;
  assign RD2E     = de_q.rd2;
  assign SignImmE = de_q.signimm;
  assign RsE      = de_q.rs;
  assign RtE      = de_q.rt;
  assign RdE      = de_q.rd;
  assign ValidE   = de_q.valid;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             flush_ev;

  // Debug counters saturate at all-ones; protocol error is sticky
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    proto_err_d = proto_err_q;
    flush_ev    = FlushE | (FlushD & ~StallD);
    if (StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ev && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if ((StallD != StallF) || (StallD && !FlushE)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign ProtoErr = proto_err_q;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Randomized and directed bench for hazard_pipe_regs against a cycle-level
// behavioural model of the pipeline slots.
module tb_hazard_pipe_regs;
  import mips_pipe_pkg::*;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, StallF, StallD, FlushD, FlushE;
  logic [31:0]   PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD;
  ctrl_t         CtrlD, CtrlE;
  logic [4:0]    RsD, RtD, RdD, RsE, RtE, RdE;
  logic [31:0]   PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
  logic          ValidD, ValidE, ProtoErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  hazard_pipe_regs #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D),
    .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .PCF(PCF),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .ValidE(ValidE),
    .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .StallCnt(StallCnt),
    .FlushCnt(FlushCnt), .ProtoErr(ProtoErr)
  );

  int tests = 0;
  int fails = 0;

  // Model of what each pipeline slot should hold
  logic [31:0] m_pc, m_instrd, m_pcp4d, m_rd1e, m_rd2e, m_imme;
  logic        m_vd, m_ve, m_pe;
  ctrl_t       m_ctrle;
  logic [4:0]  m_rse, m_rte, m_rde;
  int          m_sc, m_fc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs held across the edge
  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0; m_instrd = '0; m_pcp4d = '0; m_vd = 1'b0;
      m_ctrle = '0; m_rd1e = '0; m_rd2e = '0; m_imme = '0;
      m_rse = '0; m_rte = '0; m_rde = '0; m_ve = 1'b0;
      m_sc = 0; m_fc = 0; m_pe = 1'b0;
    end else begin
      if (StallD) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
      if (FlushE || (FlushD && !StallD)) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
      if ((StallD != StallF) || (StallD && !FlushE)) m_pe = 1'b1;
      if (FlushE) begin
        m_ctrle = '0; m_rd1e = '0; m_rd2e = '0; m_imme = '0;
        m_rse = '0; m_rte = '0; m_rde = '0; m_ve = 1'b0;
      end else begin
        m_ctrle = CtrlD; m_rd1e = RD1D; m_rd2e = RD2D; m_imme = SignImmD;
        m_rse = RsD; m_rte = RtD; m_rde = RdD; m_ve = m_vd;
      end
      if (!StallD) begin
        if (FlushD) begin
          m_instrd = '0; m_pcp4d = '0; m_vd = 1'b0;
        end else begin
          m_instrd = InstrF; m_pcp4d = PCPlus4F; m_vd = 1'b1;
        end
      end
      if (!StallF) m_pc = PCNextF;
    end
  endtask

  task automatic check_all();
    check_eq("PCF", 64'(PCF), 64'(m_pc));
    check_eq("InstrD", 64'(InstrD), 64'(m_instrd));
    check_eq("PCPlus4D", 64'(PCPlus4D), 64'(m_pcp4d));
    check_eq("ValidD", 64'(ValidD), 64'(m_vd));
    check_eq("ValidE", 64'(ValidE), 64'(m_ve));
    check_eq("CtrlE", 64'(CtrlE), 64'(m_ctrle));
    check_eq("RD1E", 64'(RD1E), 64'(m_rd1e));
    check_eq("RD2E", 64'(RD2E), 64'(m_rd2e));
    check_eq("SignImmE", 64'(SignImmE), 64'(m_imme));
    check_eq("RsRtRdE", 64'({RsE, RtE, RdE}), 64'({m_rse, m_rte, m_rde}));
    check_eq("StallCnt", 64'(StallCnt), 64'(m_sc));
    check_eq("FlushCnt", 64'(FlushCnt), 64'(m_fc));
    check_eq("ProtoErr", 64'(ProtoErr), 64'(m_pe));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic rand_data();
    InstrF = $urandom; PCPlus4F = $urandom; RD1D = $urandom; RD2D = $urandom;
    SignImmD = $urandom; CtrlD = ctrl_t'($urandom_range(0, 255));
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic legal_idle();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
  endtask

  logic [31:0] saved_pc, saved_instr;

  initial begin
    reset = 1'b1; legal_idle(); PCNextF = '0; rand_data();
    @(negedge clk);
    cycle();
    check_eq("rst_PCF", 64'(PCF), 64'h0);
    check_eq("rst_CtrlE", 64'(CtrlE), 64'h0);
    reset = 1'b0;

    // Free run with sequential PC, lw travels F -> D -> E
    PCNextF = PCF + 32'd4; InstrF = 32'h8C08_0004; PCPlus4F = 32'd4;
    cycle();
    check_eq("run_PCF4", 64'(PCF), 64'd4);
    check_eq("run_InstrD", 64'(InstrD), 64'h8C08_0004);
    PCNextF = PCF + 32'd4; InstrF = 32'h0000_0020; PCPlus4F = 32'd8;
    CtrlD = '{regwrite: 1'b1, memtoreg: 1'b1, memwrite: 1'b0,
              alucontrol: 3'b010, alusrc: 1'b1, regdst: 1'b0};
    RsD = 5'd0; RtD = 5'd8; RdD = 5'd0; SignImmD = 32'd4;
    cycle();
    check_eq("run_PCF8", 64'(PCF), 64'd8);
    check_eq("run_CtrlE", 64'(CtrlE), 64'h0000_00CA);
    check_eq("run_RtE", 64'(RtE), 64'd8);
    check_eq("run_ValidE", 64'(ValidE), 64'd1);

    // lw-use stall: hold F and D, bubble into E
    saved_pc = PCF; saved_instr = InstrD;
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; PCNextF = 32'h1234; rand_data();
    cycle();
    check_eq("lwuse_PCF", 64'(PCF), 64'(saved_pc));
    check_eq("lwuse_InstrD", 64'(InstrD), 64'(saved_instr));
    check_eq("lwuse_CtrlE", 64'(CtrlE), 64'h0);
    check_eq("lwuse_ValidE", 64'(ValidE), 64'h0);
    check_eq("lwuse_StallCnt", 64'(StallCnt), 64'd1);
    check_eq("lwuse_FlushCnt", 64'(FlushCnt), 64'd1);
    check_eq("lwuse_ProtoErr", 64'(ProtoErr), 64'd0);

    // Taken branch clears F/D and redirects PC
    legal_idle(); FlushD = 1'b1; PCNextF = 32'h40; rand_data();
    cycle();
    check_eq("br_InstrD", 64'(InstrD), 64'h0);
    check_eq("br_ValidD", 64'(ValidD), 64'h0);
    check_eq("br_PCF", 64'(PCF), 64'h40);
    check_eq("br_FlushCnt", 64'(FlushCnt), 64'd2);

    // Stall beats flush on F/D
    legal_idle(); PCNextF = 32'h44; rand_data();
    cycle();
    saved_instr = InstrD;
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b1; rand_data();
    cycle();
    check_eq("stfl_InstrD", 64'(InstrD), 64'(saved_instr));
    check_eq("stfl_ValidD", 64'(ValidD), 64'd1);

    // Illegal stall mismatch sets a sticky error
    legal_idle(); StallD = 1'b1; FlushE = 1'b1;
    cycle();
    check_eq("perr_set", 64'(ProtoErr), 64'd1);
    legal_idle();
    repeat (3) cycle();
    check_eq("perr_sticky", 64'(ProtoErr), 64'd1);
    reset = 1'b1;
    cycle();
    check_eq("perr_clr", 64'(ProtoErr), 64'd0);
    reset = 1'b0;

    // Stall held long enough to saturate the counter, then reset mid-stall
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; FlushD = 1'b0;
    repeat (20) cycle();
    check_eq("sat_StallCnt", 64'(StallCnt), 64'(CNT_MAX));
    reset = 1'b1; PCNextF = 32'hDEAD_BEE0;
    cycle();
    check_eq("rstmid_StallCnt", 64'(StallCnt), 64'd0);
    check_eq("rstmid_PCF", 64'(PCF), 64'h0);
    reset = 1'b0;

    // Random traffic, mostly legal hazard combinations
    for (int i = 0; i < 600; i++) begin
      logic s;
      reset   = ($urandom_range(0, 63) == 0);
      s       = ($urandom_range(0, 3) == 0);
      StallD  = s;
      StallF  = ($urandom_range(0, 19) == 0) ? ~s : s;
      FlushE  = s ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 5) == 0);
      FlushD  = ($urandom_range(0, 5) == 0);
      PCNextF = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
      rand_data();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
